// File: rtl/dual_port_mem.sv
// Dual-port word memory: port A read/write with byte enables, port B read-only,
// self-clearing after reset. Define MEM_BYPASS_EN to forward same-cycle A writes to B reads.
module dual_port_mem #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 65536
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                a_req_i,
    input  logic                a_wen_i,
    input  logic [ADDR_W-1:0]   a_addr_i,
    input  logic [DATA_W-1:0]   a_wdata_i,
    input  logic [DATA_W/8-1:0] a_be_i,
    output logic                a_ready_o,
    output logic                a_rvalid_o,
    output logic [DATA_W-1:0]   a_rdata_o,
    output logic                a_err_o,
    input  logic                b_req_i,
    input  logic [ADDR_W-1:0]   b_addr_i,
    output logic                b_rvalid_o,
    output logic [DATA_W-1:0]   b_rdata_o,
    output logic                init_busy_o
);

    localparam int              BE_W    = DATA_W / 8;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    typedef enum logic {INIT, RUN} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                a_rvalid_q, a_rvalid_d;
    logic                a_err_q, a_err_d;
    logic [DATA_W-1:0]   a_rdata_q, a_rdata_d;
    logic                b_rvalid_q, b_rvalid_d;
    logic [DATA_W-1:0]   b_rdata_q, b_rdata_d;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                aAccept, aInRange, aWrite;
    logic                bAccept, bInRange;
    logic [DATA_W-1:0]   aMerged;

    // State, clear counter and registered read outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= INIT;
            cnt_q      <= '0;
            a_rvalid_q <= 1'b0;
            a_err_q    <= 1'b0;
            a_rdata_q  <= '0;
            b_rvalid_q <= 1'b0;
            b_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_rvalid_q <= a_rvalid_d;
            a_err_q    <= a_err_d;
            a_rdata_q  <= a_rdata_d;
            b_rvalid_q <= b_rvalid_d;
            b_rdata_q  <= b_rdata_d;
        end
    end

    // Next-state logic, request acceptance and read-data selection
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_rvalid_d  = 1'b0;
        a_err_d     = 1'b0;
        a_rdata_d   = a_rdata_q;
        b_rvalid_d  = 1'b0;
        b_rdata_d   = b_rdata_q;

        init_busy_o = rst | (state_q == INIT);
        a_ready_o   = ~init_busy_o;

        aAccept  = a_req_i & a_ready_o;
        bAccept  = b_req_i & a_ready_o;
        aInRange = {1'b0, a_addr_i} < DEPTH_L;
        bInRange = {1'b0, b_addr_i} < DEPTH_L;

        aMerged = mem[a_addr_i];
        for (int i = 0; i < BE_W; i++) begin
            if (a_be_i[i]) begin
                aMerged[8*i +: 8] = a_wdata_i[8*i +: 8];
            end
        end
        aWrite = aAccept & a_wen_i & aInRange & (|a_be_i);

        case (state_q)
            INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (aAccept) begin
                    a_err_d = ~aInRange;
                    if (!a_wen_i) begin
                        a_rvalid_d = 1'b1;
                        a_rdata_d  = aInRange ? mem[a_addr_i] : '0;
                    end
                end
                if (bAccept) begin
                    b_rvalid_d = 1'b1;
                    b_rdata_d  = bInRange ? mem[b_addr_i] : '0;
`ifdef MEM_BYPASS_EN
                    if (bInRange && aWrite && (b_addr_i == a_addr_i)) begin
                        b_rdata_d = aMerged;
                    end
`endif
                end
            end
            default: state_d = INIT;
        endcase
    end

    // Single write path: clear sweep during INIT, port A writes in RUN
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == INIT) begin
                mem[cnt_q] <= '0;
            end else if (aWrite) begin
                mem[a_addr_i] <= aMerged;
            end
        end
    end

    assign a_rvalid_o = a_rvalid_q;
    assign a_err_o    = a_err_q;
    assign a_rdata_o  = a_rdata_q;
    assign b_rvalid_o = b_rvalid_q;
    assign b_rdata_o  = b_rdata_q;

endmodule

// File: tb/tb_dual_port_mem.sv
// Directed self-checking bench for dual_port_mem (DATA_W=16, ADDR_W=8, DEPTH=200).
// Expected collision result follows MEM_BYPASS_EN when the bench is built with it.
module tb_dual_port_mem;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 200;

    logic              clk = 1'b0;
    logic              rst;
    logic              a_req, a_wen;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic [1:0]        a_be;
    logic              a_ready, a_rvalid, a_err;
    logic [DATA_W-1:0] a_rdata;
    logic              b_req;
    logic [ADDR_W-1:0] b_addr;
    logic              b_rvalid;
    logic [DATA_W-1:0] b_rdata;
    logic              init_busy;

    int checkCount = 0;
    int passCount  = 0;
    int n;
    logic [DATA_W-1:0] collideExp;

    dual_port_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .a_req_i    (a_req),
        .a_wen_i    (a_wen),
        .a_addr_i   (a_addr),
        .a_wdata_i  (a_wdata),
        .a_be_i     (a_be),
        .a_ready_o  (a_ready),
        .a_rvalid_o (a_rvalid),
        .a_rdata_o  (a_rdata),
        .a_err_o    (a_err),
        .b_req_i    (b_req),
        .b_addr_i   (b_addr),
        .b_rvalid_o (b_rvalid),
        .b_rdata_o  (b_rdata),
        .init_busy_o(init_busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of requests at a negedge; outputs are sampled at the following negedge.
    task automatic applyStimulus(input logic aReq, input logic aWen, input logic [ADDR_W-1:0] aAddr,
                                 input logic [DATA_W-1:0] aWdata, input logic [1:0] aBe,
                                 input logic bReq, input logic [ADDR_W-1:0] bAddr);
        a_req   = aReq;
        a_wen   = aWen;
        a_addr  = aAddr;
        a_wdata = aWdata;
        a_be    = aBe;
        b_req   = bReq;
        b_addr  = bAddr;
        @(negedge clk);
        a_req = 1'b0;
        b_req = 1'b0;
    endtask

    task automatic waitInitDone(output int cycles);
        cycles = 0;
        while (init_busy && cycles < 1000) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    initial begin
        rst = 1'b1; a_req = 1'b0; a_wen = 1'b0; a_addr = '0; a_wdata = '0; a_be = '0;
        b_req = 1'b0; b_addr = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst_init_busy", init_busy, 1);
        checkOutput("rst_a_ready", a_ready, 0);
        checkOutput("rst_a_rvalid", a_rvalid, 0);
        checkOutput("rst_a_err", a_err, 0);
        checkOutput("rst_b_rvalid", b_rvalid, 0);
        checkOutput("rst_a_rdata", a_rdata, 0);
        checkOutput("rst_b_rdata", b_rdata, 0);

        // Clear sequence with a write/read attempt at init cycle 10
        rst = 1'b0;
        n = 0;
        repeat (9) begin @(negedge clk); n++; end
        a_req = 1'b1; a_wen = 1'b1; a_addr = 8'h03; a_wdata = 16'hFFFF; a_be = 2'b11;
        b_req = 1'b1; b_addr = 8'h03;
        checkOutput("init_a_ready", a_ready, 0);
        @(negedge clk); n++;
        a_req = 1'b0; b_req = 1'b0;
        checkOutput("init_a_rvalid", a_rvalid, 0);
        checkOutput("init_a_err", a_err, 0);
        checkOutput("init_b_rvalid", b_rvalid, 0);
        while (init_busy && n < 1000) begin @(negedge clk); n++; end
        checkOutput("init_cycles", n, 200);
        checkOutput("run_a_ready", a_ready, 1);

        applyStimulus(1, 0, 8'h05, 16'h0, 2'b00, 0, 8'h00);
        checkOutput("rd05_rvalid", a_rvalid, 1);
        checkOutput("rd05_rdata", a_rdata, 16'h0000);
        applyStimulus(1, 0, 8'h03, 16'h0, 2'b00, 0, 8'h00);
        checkOutput("rd03_rdata", a_rdata, 16'h0000);
        applyStimulus(0, 0, 8'h00, 16'h0, 2'b00, 0, 8'h00);
        checkOutput("idle_rvalid", a_rvalid, 0);

        // Byte merge
        applyStimulus(1, 1, 8'h10, 16'hABCD, 2'b11, 0, 8'h00);
        checkOutput("wr10_rvalid", a_rvalid, 0);
        checkOutput("wr10_err", a_err, 0);
        applyStimulus(1, 1, 8'h10, 16'h0012, 2'b01, 0, 8'h00);
        applyStimulus(1, 0, 8'h10, 16'h0, 2'b00, 0, 8'h00);
        checkOutput("merge_lo", a_rdata, 16'hAB12);
        applyStimulus(1, 1, 8'h10, 16'hFFFF, 2'b00, 0, 8'h00);
        applyStimulus(1, 0, 8'h10, 16'h0, 2'b00, 0, 8'h00);
        checkOutput("be0_noop", a_rdata, 16'hAB12);
        applyStimulus(1, 1, 8'h10, 16'h5600, 2'b10, 0, 8'h00);
        applyStimulus(1, 0, 8'h10, 16'h0, 2'b00, 0, 8'h00);
        checkOutput("merge_hi", a_rdata, 16'h5612);

        // Same-address collision
`ifdef MEM_BYPASS_EN
        collideExp = 16'h1234;
`else
        collideExp = 16'h0000;
`endif
        applyStimulus(1, 1, 8'h20, 16'h1234, 2'b11, 1, 8'h20);
        checkOutput("collide_b_rvalid", b_rvalid, 1);
        checkOutput("collide_b_rdata", b_rdata, collideExp);
        applyStimulus(1, 0, 8'h20, 16'h0, 2'b00, 1, 8'h20);
        checkOutput("after_collide_a", a_rdata, 16'h1234);
        checkOutput("after_collide_b", b_rdata, 16'h1234);
        applyStimulus(0, 0, 8'h00, 16'h0, 2'b00, 0, 8'h00);
        checkOutput("b_hold_rvalid", b_rvalid, 0);
        checkOutput("b_hold_rdata", b_rdata, 16'h1234);
        checkOutput("a_hold_rdata", a_rdata, 16'h1234);

        // Independent ports on different addresses
        applyStimulus(1, 1, 8'h30, 16'hBEEF, 2'b11, 1, 8'h10);
        checkOutput("indep_b_rdata", b_rdata, 16'h5612);
        applyStimulus(1, 0, 8'h30, 16'h0, 2'b00, 1, 8'h20);
        checkOutput("indep_a_rdata", a_rdata, 16'hBEEF);
        checkOutput("indep_b_rdata2", b_rdata, 16'h1234);

        // Out-of-range accesses
        applyStimulus(1, 1, 8'hC7, 16'h7777, 2'b11, 0, 8'h00);
        applyStimulus(1, 1, 8'hC8, 16'h5555, 2'b11, 0, 8'h00);
        checkOutput("oor_wr_err", a_err, 1);
        checkOutput("oor_wr_rvalid", a_rvalid, 0);
        applyStimulus(1, 0, 8'hC8, 16'h0, 2'b00, 0, 8'h00);
        checkOutput("oor_rd_err", a_err, 1);
        checkOutput("oor_rd_rvalid", a_rvalid, 1);
        checkOutput("oor_rd_rdata", a_rdata, 16'h0000);
        applyStimulus(1, 0, 8'hC7, 16'h0, 2'b00, 1, 8'hFF);
        checkOutput("c7_rdata", a_rdata, 16'h7777);
        checkOutput("c7_err", a_err, 0);
        checkOutput("oor_b_rvalid", b_rvalid, 1);
        checkOutput("oor_b_rdata", b_rdata, 16'h0000);
        applyStimulus(0, 0, 8'h00, 16'h0, 2'b00, 0, 8'h00);
        checkOutput("err_pulse_end", a_err, 0);

        // Reset from RUN, then a second reset in the middle of the clear
        applyStimulus(1, 0, 8'h30, 16'h0, 2'b00, 1, 8'h10);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst2_a_rdata", a_rdata, 0);
        checkOutput("rst2_b_rdata", b_rdata, 0);
        checkOutput("rst2_init_busy", init_busy, 1);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        checkOutput("mid_init_busy", init_busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        waitInitDone(n);
        checkOutput("reinit_cycles", n, 200);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1, 0, ADDR_W'(i), 16'h0, 2'b00, 1, ADDR_W'(DEPTH - 1 - i));
            checkOutput($sformatf("clr_a_%0d", i), a_rdata, 16'h0000);
            checkOutput($sformatf("clr_b_%0d", DEPTH - 1 - i), b_rdata, 16'h0000);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/dual_port_mem.md
DUAL_PORT_MEM -- requirements
Module: dual_port_mem

Interface
REQ-001 Parameter DATA_W, default 16; data word width, multiple of 8.
REQ-002 Parameter ADDR_W, default 16; address width.
REQ-003 Parameter DEPTH, default 65536; implemented words, DEPTH <= 2^ADDR_W.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 a_req  input  1  port A request (read/write).
REQ-007 a_wen  input  1  port A write enable, active-high; 0 = read.
REQ-008 a_addr  input  ADDR_W  port A word address.
REQ-009 a_wdata  input  DATA_W  port A write data.
REQ-010 a_be  input  DATA_W/8  port A byte enables; bit i covers data bits [8i+7:8i].
REQ-011 a_ready  output  1  port A can accept a request this cycle.
REQ-012 a_rvalid  output  1  one-cycle pulse: a_rdata valid.
REQ-013 a_rdata  output  DATA_W  port A read data.
REQ-014 a_err  output  1  one-cycle pulse: accepted access was out of range.
REQ-015 b_req  input  1  port B read request (read-only port, e.g. fetch).
REQ-016 b_addr  input  ADDR_W  port B word address.
REQ-017 b_rvalid  output  1  one-cycle pulse: b_rdata valid.
REQ-018 b_rdata  output  DATA_W  port B read data.
REQ-019 init_busy  output  1  clear sequence in progress.

Function
REQ-020 Two states: INIT and RUN; reset forces INIT with clear counter = 0.
REQ-021 INIT: one word per cycle written to zero at counter address; counter +1 per cycle; INIT -> RUN after address DEPTH-1 is cleared (exactly DEPTH cycles after rst deasserts).
REQ-022 init_busy = 1 in INIT, 0 in RUN; a_ready = !init_busy.
REQ-023 In INIT all a_req/b_req are ignored: no write, no rvalid, no err.
REQ-024 Port A accepted when a_req & a_ready at edge N.
REQ-025 Accepted write: only bytes with a_be set are updated at edge N; a_be = 0 is a no-op; no a_rvalid.
REQ-026 Accepted read at N: a_rvalid = 1 and a_rdata = word during cycle N+1 (latency 1).
REQ-027 a_rdata and b_rdata hold their last value until the next valid read.
REQ-028 Read-after-write: a port A read at N+1 returns data written at N.
REQ-029 Port B: b_req in RUN at edge N -> b_rvalid = 1, b_rdata during N+1; port B is never stalled.
REQ-030 Address >= DEPTH on port A: write dropped, read returns 0; a_err pulses in cycle N+1 for reads and writes.
REQ-031 Address >= DEPTH on port B: b_rdata = 0, b_rvalid still pulses.
REQ-032 Port A and port B on different addresses in the same cycle operate independently.

Reset
REQ-033 While rst = 1: init_busy = 1, a_ready = 0, a_rvalid = 0, b_rvalid = 0, a_err = 0, a_rdata = 0, b_rdata = 0, counter = 0.
REQ-034 rst asserted mid-INIT or mid-RUN restarts a full DEPTH-cycle clear after release; no prior contents survive.

Configuration
REQ-035 Macro MEM_BYPASS_EN defined: port A write and port B read to the same address in the same cycle -> b_rdata = new byte-merged word.
REQ-036 MEM_BYPASS_EN undefined: the same collision -> b_rdata = old word; the write still completes.

Verification (DATA_W=16, ADDR_W=8, DEPTH=200)
REQ-037 Reset and clear: rst high 2 cycles, then low -> init_busy high exactly 200 cycles; then read A 0x05 -> a_rdata 0x0000 next cycle.
REQ-038 Byte merge: write A 0x10 = 0xABCD with be 11, then 0x0012 with be 01 -> read 0x10 gives 0xAB12.
REQ-039 Collision: A writes 0x1234 to 0x20 (old 0x0000) while B reads 0x20 -> b_rdata 0x1234 with MEM_BYPASS_EN, 0x0000 without; a later read gives 0x1234 in both builds.
REQ-040 Out of range: write 0x5555 to 0xC8 -> a_err pulse; read 0xC8 -> a_rdata 0x0000, a_rvalid and a_err pulse together; 0xC7 unchanged.
REQ-041 Request during INIT: a_req write 0xFFFF to 0x03 at init cycle 10 -> a_ready 0, no pulses; after INIT, 0x03 reads 0x0000.
REQ-042 Mid-init reset: rst pulse at init cycle 50 -> init_busy stays high 200 more cycles after release; all words read 0x0000 afterwards.
